// File: rtl/sw_db_pkg.sv
// ---------------------------------------------------------------------------
// sw_db_pkg
// Shared definitions for the slide-switch debouncer.
//   db_state_t         : debounce FSM state (IDLE, SETTLE)
//   DB_CYCLES_DEFAULT  : default settle window, 10 ms at 50 MHz
// ---------------------------------------------------------------------------
package sw_db_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } db_state_t;

  localparam int DB_CYCLES_DEFAULT = 500000;

endpackage : sw_db_pkg

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous vector into the clk domain.
// Ports:
//   clk   : system clock
//   clrn  : asynchronous active-low reset, clears both stages
//   d     : asynchronous input vector
//   q     : synchronized output (second stage)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;

  // One independent two-stage chain per bit; bits are not coherent with
  // each other, which the downstream settle window absorbs.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          sync1[gi] <= 1'b0;
          q[gi]     <= 1'b0;
        end else begin
          sync1[gi] <= d[gi];
          q[gi]     <= sync1[gi];
        end
      end
    end
  endgenerate

endmodule : sync_2ff

// File: rtl/sw_debounce_latch.sv
// ---------------------------------------------------------------------------
// sw_debounce_latch
// Debounces an 8-bit slide-switch vector and latches the settled value for
// a downstream 8-to-3 priority encoder.
// Ports:
//   clk     : system clock, all state on rising edge
//   clrn    : asynchronous active-low reset
//   sw      : raw bouncing switch vector (asynchronous)
//   hold    : when high, commit is suppressed and x_out stays frozen
//   x_out   : debounced stable vector
//   x_chg   : one-cycle pulse in the first cycle x_out shows a new value
//   chg_cnt : (only with SW_DB_CHG_CNT_EN defined) count of x_chg pulses,
//             wraps 255 -> 0
// Parameters:
//   DB_CYCLES : cycles the synchronized vector must hold before commit
//   CNT_W     : settle counter width, 2**CNT_W >= DB_CYCLES
// Optional feature macro: SW_DB_CHG_CNT_EN
// ---------------------------------------------------------------------------
module sw_debounce_latch
  import sw_db_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] sw,
  input  logic       hold,
  output logic [7:0] x_out,
`ifdef SW_DB_CHG_CNT_EN
  output logic [7:0] chg_cnt,
`endif
  output logic       x_chg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [7:0]       sync2;
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt;
  db_state_t        state;

  sync_2ff #(
    .WIDTH (8)
  ) u_sync (
    .clk  (clk),
    .clrn (clrn),
    .d    (sw),
    .q    (sync2)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
      x_out <= '0;
      x_chg <= 1'b0;
    end else begin
      x_chg <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2 != x_out) begin
            cand  <= sync2;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 != cand) begin
            // Any bounce restarts the settle window on the new value.
            cand <= sync2;
            cnt  <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end else if (!hold) begin
            // Counter sits at CNT_MAX while hold is high, so commit happens
            // on the first cycle hold drops. A candidate that drifted back
            // to the current output commits silently.
            x_out <= cand;
            x_chg <= (cand != x_out);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SW_DB_CHG_CNT_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      chg_cnt <= '0;
    end else if (x_chg) begin
      chg_cnt <= chg_cnt + 8'd1;
    end
  end
`endif

endmodule : sw_debounce_latch
